spi_word_responder: RTL and testbench

SPI responder (mode 0, slave) that links the image-processing core's 16-bit SPI conduit to an external SPI master such as the host microcontroller. It shifts the 16-bit readdata word offered by the image-processing side out on MISO. It assembles the master's MOSI bits into 16-bit words for the write side. All SPI pins are oversampled in the system clock domain, and the block is the pin-side counterpart of the parallel conduit.

---
 rtl/spi_word_pkg.sv | 24 ++
 rtl/spi_word_responder_sync_edge.sv | 42 ++++
 rtl/spi_word_responder.sv | 173 +++++++++++++++++
 tb/tb_spi_word_responder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_word_pkg.sv
// -----------------------------------------------------------------------------
// spi_word_pkg
// Shared definitions for the SPI word responder: default word width, the word
// sent when no transmit word is held, the responder state type and the width
// of the bit counter.
// -----------------------------------------------------------------------------
package spi_word_pkg;

    localparam int WORD_W_DEF = 16;
    localparam logic [15:0] IDLE_WORD_DEF = 16'h0000;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit counter width for a given word width (at least one bit).
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W_DEF = cnt_width(WORD_W_DEF);

endpackage

// File: rtl/spi_word_responder_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Brings one asynchronous SPI pin into the clk domain through SYNC_STAGES
// flops, then compares against one more delayed copy to flag edges.
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   i_pin    raw pin
//   o_level  synchronized level
//   o_rise   one-cycle strobe on a synchronized 0->1 transition
//   o_fall   one-cycle strobe on a synchronized 1->0 transition
// RESET_VAL is the pin's idle level, so releasing reset never fakes an edge.
// -----------------------------------------------------------------------------
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/spi_word_responder.sv
// -----------------------------------------------------------------------------
// spi_word_responder
// Mode-0 SPI slave that shifts 16-bit words from the image-processing side out
// on MISO and assembles MOSI bits into words for the write side. All pins are
// oversampled in the clk domain.
//   clk, reset_n           system clock, asynchronous active-low reset
//   spi_sclk/cs_n/mosi     SPI pins from the master
//   spi_miso, spi_miso_oe  responder data and its output enable
//   tx_data/valid/ready    one-word holding register, filled by the core
//   rx_data, rx_valid      last complete received word and its update strobe
//   frame_err              strobe: cs_n deasserted in the middle of a word
//   tx_underrun            strobe: IDLE_WORD started going out
// -----------------------------------------------------------------------------
module spi_word_responder
    import spi_word_pkg::*;
#(
    parameter int                WORD_W      = WORD_W_DEF,
    parameter int                SYNC_STAGES = 2,
    parameter logic [WORD_W-1:0] IDLE_WORD   = WORD_W'(IDLE_WORD_DEF)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic [WORD_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              tx_underrun
);

    localparam int CNT_W = cnt_width(WORD_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    logic w_sclk_rise, w_sclk_fall, w_sclk_lvl_unused;
    logic w_cs_rise, w_cs_fall, w_cs_lvl_unused;
    logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .i_clk(clk), .i_rst_n(reset_n), .i_pin(spi_sclk),
        .o_level(w_sclk_lvl_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .i_clk(clk), .i_rst_n(reset_n), .i_pin(spi_cs_n),
        .o_level(w_cs_lvl_unused), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .i_clk(clk), .i_rst_n(reset_n), .i_pin(spi_mosi),
        .o_level(w_mosi), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused)
    );

    state_t             r_state;
    logic [WORD_W-1:0]  r_hold;
    logic               r_hold_full;
    logic               r_tx_ready;
    logic [WORD_W-1:0]  r_shreg;
    logic               r_from_hold;
    logic [WORD_W-1:0]  r_rxsh;
    logic [CNT_W-1:0]   r_bit_cnt;
    // Set on the last rise of a word so the following sclk fall loads the next.
    logic               r_word_done;
    logic               r_miso;
    logic               r_miso_oe;
    logic [WORD_W-1:0]  r_rx_data;
    logic               r_rx_valid;
    logic               r_frame_err;
    logic               r_tx_underrun;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_hold        <= '0;
            r_hold_full   <= 1'b0;
            r_tx_ready    <= 1'b1;
            r_shreg       <= '0;
            r_from_hold   <= 1'b0;
            r_rxsh        <= '0;
            r_bit_cnt     <= '0;
            r_word_done   <= 1'b0;
            r_miso        <= 1'b0;
            r_miso_oe     <= 1'b0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_frame_err   <= 1'b0;
            r_tx_underrun <= 1'b0;
        end else begin
            r_rx_valid    <= 1'b0;
            r_frame_err   <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_miso        <= (r_state == SHIFT) ? r_shreg[WORD_W-1] : 1'b0;

            // Capture and pop are mutually exclusive: capture needs the
            // register empty, pop needs it full. A load in the same cycle
            // as a capture sees the old (empty) flag.
            if (tx_valid && !r_hold_full) begin
                r_hold      <= tx_data;
                r_hold_full <= 1'b1;
                r_tx_ready  <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_cs_fall) begin
                        r_state     <= SHIFT;
                        r_miso_oe   <= 1'b1;
                        r_bit_cnt   <= '0;
                        r_word_done <= 1'b0;
                        r_shreg     <= r_hold_full ? r_hold : IDLE_WORD;
                        r_from_hold <= r_hold_full;
                    end
                end
                SHIFT: begin
                    if (w_cs_rise) begin
                        r_state     <= IDLE;
                        r_miso_oe   <= 1'b0;
                        r_word_done <= 1'b0;
                        if (r_bit_cnt != '0) begin
                            r_frame_err <= 1'b1;
                            r_bit_cnt   <= '0;
                        end
                    end else if (w_sclk_rise) begin
                        r_rxsh <= {r_rxsh[WORD_W-2:0], w_mosi};
                        // The first rise commits the loaded word: pop the
                        // holding register or report that IDLE_WORD went out.
                        if (r_bit_cnt == '0) begin
                            r_word_done <= 1'b0;
                            if (r_from_hold) begin
                                r_hold_full <= 1'b0;
                                r_tx_ready  <= 1'b1;
                                r_from_hold <= 1'b0;
                            end else begin
                                r_tx_underrun <= 1'b1;
                            end
                        end
                        if (r_bit_cnt == LAST_BIT) begin
                            r_bit_cnt   <= '0;
                            r_rx_data   <= {r_rxsh[WORD_W-2:0], w_mosi};
                            r_rx_valid  <= 1'b1;
                            r_word_done <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else if (w_sclk_fall) begin
                        if (r_bit_cnt != '0) begin
                            r_shreg <= {r_shreg[WORD_W-2:0], 1'b0};
                        end else if (r_word_done) begin
                            r_word_done <= 1'b0;
                            r_shreg     <= r_hold_full ? r_hold : IDLE_WORD;
                            r_from_hold <= r_hold_full;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign spi_miso    = r_miso;
    assign spi_miso_oe = r_miso_oe;
    assign tx_ready    = r_tx_ready;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign frame_err   = r_frame_err;
    assign tx_underrun = r_tx_underrun;

endmodule

// File: tb/tb_spi_word_responder.sv
module tb_spi_word_responder;

    localparam int H = 6;  // clk cycles per sclk phase

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        spi_sclk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic [15:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        frame_err;
    logic        tx_underrun;

    always #5 clk = ~clk;

    spi_word_responder dut (
        .clk(clk), .reset_n(reset_n),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .frame_err(frame_err), .tx_underrun(tx_underrun)
    );

    int n_total = 0;
    int n_pass  = 0;
    int cnt_rxv = 0;
    int cnt_fe  = 0;
    int cnt_ur  = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_rx = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    // Scoreboard: received words are compared in order against expectations
    // pushed when the corresponding MOSI frame was driven.
    always @(negedge clk) begin
        if (reset_n) begin
            if (rx_valid) begin
                cnt_rxv++;
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL rx_unexpected: got word %0h, required no rx_valid", rx_data);
                end else begin
                    check("rx_data", {16'h0, rx_data}, {16'h0, exp_q.pop_front()});
                end
            end
            if (frame_err)   cnt_fe++;
            if (tx_underrun) cnt_ur++;
        end
    end

    task automatic give(input logic [15:0] w);
        int n;
        n = 0;
        while (!tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) begin
            n_total++;
            $display("FAIL give_timeout: tx_ready got 0, required 1 within 2000 cycles");
        end else begin
            tx_data  = w;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
        end
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        repeat (H) @(negedge clk);
        check("miso_oe_selected", {31'h0, spi_miso_oe}, 32'h1);
    endtask

    task automatic cs_high();
        spi_cs_n = 1'b1;
        repeat (H + 2) @(negedge clk);
        check("miso_oe_deselected", {31'h0, spi_miso_oe}, 32'h0);
    endtask

    // Shifts nbits MSB-first; MISO is sampled just before each rising edge.
    task automatic xfer(input logic [15:0] w, input int nbits, output logic [15:0] m);
        m = '0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = w[15-i];
            repeat (H) @(negedge clk);
            m = {m[14:0], spi_miso};
            spi_sclk = 1'b1;
            repeat (H) @(negedge clk);
            spi_sclk = 1'b0;
        end
        repeat (H) @(negedge clk);
    endtask

    task automatic do_frame(input logic [15:0] mosi, output logic [15:0] miso);
        exp_q.push_back(mosi);
        last_rx = mosi;
        cs_low();
        xfer(mosi, 16, miso);
        cs_high();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"},      {31'h0, spi_miso},    32'h0);
        check({tag, "_miso_oe"},   {31'h0, spi_miso_oe}, 32'h0);
        check({tag, "_tx_ready"},  {31'h0, tx_ready},    32'h1);
        check({tag, "_rx_data"},   {16'h0, rx_data},     32'h0);
        check({tag, "_rx_valid"},  {31'h0, rx_valid},    32'h0);
        check({tag, "_frame_err"}, {31'h0, frame_err},   32'h0);
        check({tag, "_underrun"},  {31'h0, tx_underrun}, 32'h0);
    endtask

    typedef struct {
        logic        have_tx;
        logic [15:0] tx;
        logic [15:0] mosi;
        logic [15:0] miso;
        int          ur;
    } vec_t;

    vec_t vt[4];

    initial begin
        logic [15:0] m, m2;
        int b_rxv, b_fe, b_ur;

        vt[0] = '{1'b1, 16'hA5C3, 16'h1234, 16'hA5C3, 0};
        vt[1] = '{1'b0, 16'h0000, 16'hFFFF, 16'h0000, 1};
        vt[2] = '{1'b1, 16'h8001, 16'h0000, 16'h8001, 0};
        vt[3] = '{1'b1, 16'hFFFF, 16'h5A5A, 16'hFFFF, 0};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Single-word frames, with and without a held word.
        for (int i = 0; i < 4; i++) begin
            if (vt[i].have_tx) give(vt[i].tx);
            b_rxv = cnt_rxv; b_ur = cnt_ur; b_fe = cnt_fe;
            do_frame(vt[i].mosi, m);
            check($sformatf("vec%0d_miso", i), {16'h0, m}, {16'h0, vt[i].miso});
            check($sformatf("vec%0d_underrun", i), cnt_ur - b_ur, vt[i].ur);
            check($sformatf("vec%0d_rx_valid_cnt", i), cnt_rxv - b_rxv, 1);
            check($sformatf("vec%0d_frame_err_cnt", i), cnt_fe - b_fe, 0);
            check($sformatf("vec%0d_tx_ready", i), {31'h0, tx_ready}, 32'h1);
        end

        // Two words inside one cs_n, second word supplied after the first pop.
        give(16'h0001);
        b_rxv = cnt_rxv; b_ur = cnt_ur;
        exp_q.push_back(16'hBEEF);
        exp_q.push_back(16'hCAFE);
        last_rx = 16'hCAFE;
        cs_low();
        fork
            begin
                xfer(16'hBEEF, 16, m);
                xfer(16'hCAFE, 16, m2);
            end
            give(16'h8000);
        join
        cs_high();
        check("b2b_miso_word0", {16'h0, m},  32'h0001);
        check("b2b_miso_word1", {16'h0, m2}, 32'h8000);
        check("b2b_rx_valid_cnt", cnt_rxv - b_rxv, 2);
        check("b2b_underrun", cnt_ur - b_ur, 0);

        // Abort after 7 clocks, then a clean frame.
        b_rxv = cnt_rxv; b_fe = cnt_fe;
        cs_low();
        xfer(16'hF0F0, 7, m);
        cs_high();
        check("abort_frame_err", cnt_fe - b_fe, 1);
        check("abort_rx_valid_cnt", cnt_rxv - b_rxv, 0);
        check("abort_rx_data_kept", {16'h0, rx_data}, {16'h0, last_rx});
        b_fe = cnt_fe;
        do_frame(16'h00FF, m);
        check("post_abort_rx_data", {16'h0, rx_data}, 32'h00FF);
        check("post_abort_frame_err", cnt_fe - b_fe, 0);

        // Select without clocks keeps the held word for the next frame.
        give(16'h5555);
        b_rxv = cnt_rxv; b_fe = cnt_fe; b_ur = cnt_ur;
        spi_cs_n = 1'b0;
        repeat (50) @(negedge clk);
        check("noclk_tx_ready", {31'h0, tx_ready}, 32'h0);
        check("noclk_pulses", (cnt_rxv - b_rxv) + (cnt_fe - b_fe) + (cnt_ur - b_ur), 0);
        cs_high();
        check("noclk_frame_err", cnt_fe - b_fe, 0);
        b_ur = cnt_ur;
        do_frame(16'h6B6B, m);
        check("noclk_next_miso", {16'h0, m}, 32'h5555);
        check("noclk_next_underrun", cnt_ur - b_ur, 0);

        // Asynchronous reset after bit 9.
        give(16'h7777);
        cs_low();
        xfer(16'h3C3C, 9, m);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("midreset");
        repeat (3) @(negedge clk);
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        give(16'h1357);
        b_rxv = cnt_rxv; b_ur = cnt_ur; b_fe = cnt_fe;
        do_frame(16'h2468, m);
        check("after_reset_miso", {16'h0, m}, 32'h1357);
        check("after_reset_underrun", cnt_ur - b_ur, 0);
        check("after_reset_rx_valid_cnt", cnt_rxv - b_rxv, 1);
        check("after_reset_frame_err", cnt_fe - b_fe, 0);

        repeat (4) @(negedge clk);
        check("rx_queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
